io_hub: RTL and testbench

Memory-mapped peripheral port block for the AVR core's I/O space. It decodes core port reads and writes at a parametrised base address and drives the SD controller command interface and the video page and border registers. It buffers keyboard codes in a FIFO, keeps a programmable tick timer, and collects sticky event flags into a maskable interrupt request. It sits between the core's I/O bus and the SD, video and keyboard peripherals.

---
 rtl/io_hub.sv | 172 +++++++++++++++++
 tb/tb_io_hub.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_hub.sv
// rtl/io_hub.sv - memory-mapped I/O port hub: SD command, video regs, keyboard FIFO, tick timer, irq
//
// Ports:
//   clock, reset_n            system clock, synchronous active-low reset
//   a, o, r, w                core port address, write data, read/write strobes
//   p                         combinational read data (0 outside BASE..BASE+8)
//   sd_command, sd_rw, sd_lba SD controller command interface
//   sd_card, sd_error,
//   sd_done, sd_busy          SD controller status
//   p_vpage, p_border         video page select and border colour
//   p_vblank                  frame-end pulse
//   p_kdone, p_ascii          keyboard code valid pulse and code
//   irq                       registered interrupt request
module io_hub #(
  parameter logic [15:0] BASE    = 16'h0020,
  parameter int          CLK_HZ  = 25000000,
  parameter int          TICK_HZ = 100,
  parameter int          KDEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [7:0]  o,
  input  logic        r,
  input  logic        w,
  output logic [7:0]  p,
  output logic        sd_command,
  output logic        sd_rw,
  output logic [31:0] sd_lba,
  input  logic [1:0]  sd_card,
  input  logic [3:0]  sd_error,
  input  logic        sd_done,
  input  logic        sd_busy,
  output logic        p_vpage,
  output logic [2:0]  p_border,
  input  logic        p_vblank,
  input  logic        p_kdone,
  input  logic [7:0]  p_ascii,
  output logic        irq
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int AW  = $clog2(KDEPTH);
  localparam int CW  = AW + 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] presc_q;
  logic [7:0]    tick_q;
  logic          tick_f_q, kovf_q, sddone_q, vbl_q;
  logic          tick_f_d, kovf_d, sddone_d, vbl_d;
  logic [4:0]    mask_q;
  logic          sd_command_q, sd_rw_q, p_vpage_q, irq_q;
  logic [31:0]   sd_lba_q;
  logic [2:0]    p_border_q;
  logic [7:0]    mem_q [KDEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  // Address decode; offsets are only meaningful when in_range is set.
  logic [15:0] off;
  logic [3:0]  sel;
  logic        in_range, rd_en, wr_en;
  assign off      = a - BASE;
  assign sel      = off[3:0];
  assign in_range = (a >= BASE) && (off <= 16'd8);
  assign rd_en    = r && in_range;
  assign wr_en    = w && in_range;

  logic kne, full, pop, push_ok, kovf_set, tick_ev, clr_evt, clr_sd;
  logic [7:0] status;
  assign kne      = (count_q != '0);
  assign full     = (count_q == CW'(KDEPTH));
  assign pop      = rd_en && (sel == 4'd0) && kne;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = p_kdone && (!full || pop);
  assign kovf_set = p_kdone && full && !pop;
  assign tick_ev  = (presc_q == PMAX);
  assign clr_evt  = rd_en && (sel == 4'd2);
  assign clr_sd   = rd_en && ((sel == 4'd2) || (sel == 4'd3));
  assign status   = {3'b000, tick_f_q, kovf_q, sddone_q, vbl_q, kne};

  // Clear first, then set, so a coincident event keeps its flag.
  always_comb begin
    tick_f_d = (tick_f_q & ~clr_evt) | tick_ev;
    kovf_d   = (kovf_q   & ~clr_evt) | kovf_set;
    vbl_d    = (vbl_q    & ~clr_evt) | p_vblank;
    sddone_d = (sddone_q & ~clr_sd)  | sd_done;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    p = 8'h00;
    if (in_range) begin
      case (sel)
        4'd0:    p = kne ? mem_q[rptr_q] : 8'h00;
        4'd1:    p = tick_q;
        4'd2:    p = status;
        4'd3:    p = {sd_busy, sddone_q, sd_card, sd_error};
        4'd4:    p = {3'b000, mask_q};
        4'd8:    p = 8'(count_q);
        default: p = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q      <= '0;
      tick_q       <= 8'h00;
      tick_f_q     <= 1'b0;
      kovf_q       <= 1'b0;
      sddone_q     <= 1'b0;
      vbl_q        <= 1'b0;
      mask_q       <= 5'h00;
      sd_command_q <= 1'b0;
      sd_rw_q      <= 1'b0;
      sd_lba_q     <= 32'h0;
      p_vpage_q    <= 1'b0;
      p_border_q   <= 3'b000;
      irq_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      presc_q <= tick_ev ? '0 : presc_q + PW'(1);
      if (tick_ev) tick_q <= tick_q + 8'd1;
      tick_f_q <= tick_f_d;
      kovf_q   <= kovf_d;
      sddone_q <= sddone_d;
      vbl_q    <= vbl_d;
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      sd_command_q <= 1'b0;
      if (wr_en) begin
        case (sel)
          4'd0: p_border_q <= o[2:0];
          4'd1: p_vpage_q <= o[0];
          4'd2: sd_lba_q[7:0] <= o;
          4'd3: sd_lba_q[15:8] <= o;
          4'd4: sd_lba_q[23:16] <= o;
          4'd5: sd_lba_q[31:24] <= o;
          4'd6: if (!sd_busy) begin
            sd_command_q <= 1'b1;
            sd_rw_q      <= o[0];
          end
          4'd7: mask_q <= o[4:0];
          default: ;
        endcase
      end
      irq_q <= |(status[4:0] & mask_q);
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q] <= p_ascii;
  end

  assign sd_command = sd_command_q;
  assign sd_rw      = sd_rw_q;
  assign sd_lba     = sd_lba_q;
  assign p_vpage    = p_vpage_q;
  assign p_border   = p_border_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_io_hub.sv
// tb/tb_io_hub.sv - randomized and directed self-checking bench for io_hub
module tb_io_hub;

  localparam logic [15:0] BASE = 16'h0020;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int KDEPTH  = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] a;
  logic [7:0]  o;
  logic        r, w;
  logic [7:0]  p;
  logic        sd_command, sd_rw;
  logic [31:0] sd_lba;
  logic [1:0]  sd_card;
  logic [3:0]  sd_error;
  logic        sd_done, sd_busy;
  logic        p_vpage;
  logic [2:0]  p_border;
  logic        p_vblank, p_kdone;
  logic [7:0]  p_ascii;
  logic        irq;

  io_hub #(.BASE(BASE), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .KDEPTH(KDEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .a(a), .o(o), .r(r), .w(w), .p(p),
    .sd_command(sd_command), .sd_rw(sd_rw), .sd_lba(sd_lba),
    .sd_card(sd_card), .sd_error(sd_error), .sd_done(sd_done), .sd_busy(sd_busy),
    .p_vpage(p_vpage), .p_border(p_border), .p_vblank(p_vblank),
    .p_kdone(p_kdone), .p_ascii(p_ascii), .irq(irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: queue FIFO, edge count for the timer, plain flag bits.
  logic [7:0]  mq[$];
  bit          m_ftick, m_fkovf, m_fsd, m_fvbl;
  logic [4:0]  m_mask;
  logic [2:0]  m_border;
  bit          m_vpage, m_rw, m_cmd, m_irq;
  logic [31:0] m_lba;
  int          m_n;

  function automatic logic [7:0] m_stat();
    return {3'b000, m_ftick, m_fkovf, m_fsd, m_fvbl, mq.size() != 0};
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] addr);
    int off;
    off = int'(addr) - int'(BASE);
    case (off)
      0: return (mq.size() != 0) ? mq[0] : 8'h00;
      1: return 8'((m_n / DIV) % 256);
      2: return m_stat();
      3: return {sd_busy, m_fsd, sd_card, sd_error};
      4: return {3'b000, m_mask};
      8: return 8'(mq.size());
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clock) begin : model
    int off;
    bit rd, wr, pop, ovf, tick;
    bit irq_next;
    if (!reset_n) begin
      mq.delete();
      {m_ftick, m_fkovf, m_fsd, m_fvbl} = '0;
      m_mask = '0; m_border = '0; m_vpage = 0; m_rw = 0; m_cmd = 0; m_irq = 0;
      m_lba = '0; m_n = 0;
    end else begin
      irq_next = |(m_stat() & {3'b000, m_mask});
      off = int'(a) - int'(BASE);
      rd = r && off >= 0 && off <= 8;
      wr = w && off >= 0 && off <= 8;
      pop = rd && off == 0 && mq.size() != 0;
      if (pop) void'(mq.pop_front());
      ovf = 0;
      if (p_kdone) begin
        if (mq.size() < KDEPTH) mq.push_back(p_ascii);
        else ovf = 1;
      end
      m_n++;
      tick = (m_n % DIV) == 0;
      if (rd && off == 2) {m_ftick, m_fkovf, m_fsd, m_fvbl} = '0;
      if (rd && off == 3) m_fsd = 0;
      if (tick) m_ftick = 1;
      if (ovf) m_fkovf = 1;
      if (sd_done) m_fsd = 1;
      if (p_vblank) m_fvbl = 1;
      m_cmd = 0;
      if (wr) begin
        case (off)
          0: m_border = o[2:0];
          1: m_vpage = o[0];
          2: m_lba[7:0] = o;
          3: m_lba[15:8] = o;
          4: m_lba[23:16] = o;
          5: m_lba[31:24] = o;
          6: if (!sd_busy) begin m_cmd = 1; m_rw = o[0]; end
          7: m_mask = o[4:0];
          default: ;
        endcase
      end
      m_irq = irq_next;
    end
  end

  task automatic check_all();
    check("p", p, m_read(a));
    check("sd_command", sd_command, m_cmd);
    check("sd_rw", sd_rw, m_rw);
    check("sd_lba", sd_lba, m_lba);
    check("p_vpage", p_vpage, m_vpage);
    check("p_border", p_border, m_border);
    check("irq", irq, m_irq);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle();
    a = BASE + 16'd1; o = 0; r = 0; w = 0;
    sd_card = 0; sd_error = 0; sd_done = 0; sd_busy = 0;
    p_vblank = 0; p_kdone = 0; p_ascii = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic peek(input string tag, input int off, input logic [7:0] exp);
    a = BASE + 16'(off); r = 0; w = 0;
    #1;
    check(tag, p, exp);
  endtask

  task automatic wr_reg(input int off, input logic [7:0] d);
    a = BASE + 16'(off); o = d; w = 1;
    step();
    w = 0;
  endtask

  task automatic push(input logic [7:0] c);
    p_kdone = 1; p_ascii = c;
    step();
    p_kdone = 0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    a = BASE; r = 1;
    #1;
    check(tag, p, exp);
    step();
    r = 0;
  endtask

  initial begin
    idle();
    do_reset();

    for (int i = -1; i <= 9; i++) peek("reset_read", i, 8'h00);
    check("reset_outs", {sd_command, sd_rw, sd_lba, p_vpage, p_border, irq}, '0);

    push(8'h41); push(8'h42); push(8'h43);
    peek("fifo_count3", 8, 8'd3);
    pop_chk("pop_41", 8'h41);
    pop_chk("pop_42", 8'h42);
    pop_chk("pop_43", 8'h43);
    peek("kne_clear", 2, 8'h00);
    pop_chk("pop_empty", 8'h00);

    do_reset();
    for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
    peek("ovf_count", 8, 8'd8);
    peek("ovf_kovf", 2, 8'h09);
    for (int i = 0; i < 8; i++) pop_chk("ovf_data", 8'h60 + 8'(i));

    do_reset();
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    a = BASE; r = 1; p_kdone = 1; p_ascii = 8'h78;
    step();
    r = 0; p_kdone = 0;
    peek("full_pp_count", 8, 8'd8);
    peek("full_pp_kovf", 2, 8'h01);

    wr_reg(2, 8'h01); wr_reg(3, 8'h02); wr_reg(4, 8'h03); wr_reg(5, 8'h04);
    check("sd_lba_seq", sd_lba, 32'h04030201);
    wr_reg(6, 8'h01);
    check("sd_cmd_pulse", {sd_command, sd_rw}, 2'b11);
    step();
    check("sd_cmd_drop", sd_command, 1'b0);
    sd_busy = 1;
    wr_reg(6, 8'h00);
    check("sd_cmd_busy", {sd_command, sd_rw}, 2'b01);
    sd_busy = 0;

    do_reset();
    wr_reg(7, 8'h04);
    sd_done = 1;
    step();
    sd_done = 0;
    check("irq_lat1", irq, 1'b0);
    step();
    check("irq_rise", irq, 1'b1);
    a = BASE + 16'd3; r = 1;
    step();
    r = 0;
    check("irq_hold", irq, 1'b1);
    step();
    check("irq_fall", irq, 1'b0);
    a = BASE + 16'd3; r = 1; sd_done = 1;
    step();
    r = 0; sd_done = 0;
    peek("sddone_set_wins", 2, 8'h04);

    // Random traffic including occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      a        = BASE - 16'd1 + 16'($urandom_range(0, 10));
      o        = 8'($urandom);
      r        = ($urandom_range(0, 3) == 0);
      w        = ($urandom_range(0, 3) == 0);
      sd_card  = 2'($urandom);
      sd_error = 4'($urandom);
      sd_done  = ($urandom_range(0, 9) == 0);
      sd_busy  = ($urandom_range(0, 2) == 0);
      p_vblank = ($urandom_range(0, 15) == 0);
      p_kdone  = ($urandom_range(0, 2) == 0);
      p_ascii  = 8'($urandom);
      reset_n  = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1;

    do_reset();
    a = BASE + 16'd1;
    for (int i = 0; i < DIV - 1; i++) step();
    peek("tick_before", 1, 8'd0);
    step();
    peek("tick_first", 1, 8'd1);
    peek("tick_flag1", 2, 8'h10);
    a = BASE + 16'd1;
    for (int i = DIV; i < 2560 * DIV; i++) step();
    peek("tick_wrap", 1, 8'd0);
    peek("tick_flag_wrap", 2, 8'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
